scanout_arb: RTL and testbench



---
 rtl/video_pkg.sv | 13 +
 rtl/pix_fifo.sv | 49 ++++
 rtl/scanout_arb.sv | 188 ++++++++++++++++++
 tb/tb_scanout_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and default raster geometry for the scanout arbiter and the HDMI video block.
package video_pkg;

  localparam int VIDEO_H_ACTIVE = 720;
  localparam int VIDEO_V_ACTIVE = 480;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {IDLE, SCAN, GPU} arb_state_e;

  typedef enum logic {TAG_SCAN, TAG_GPU} rd_tag_e;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO with show-ahead head output; DEPTH must be a power of two.
module pix_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  pixel_t                   push_data,
  input  logic                     pop,
  output pixel_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/scanout_arb.sv
// VRAM arbiter between raster scanout prefetch and GPU accesses, feeding the video pixel handshake.
// Optional SCANOUT_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module scanout_arb
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = VIDEO_H_ACTIVE,
  parameter int V_ACTIVE   = VIDEO_V_ACTIVE,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [23:0]       gpu_wdata,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [23:0]       gpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       vid_data,
  output logic              vid_en,
  input  logic              vid_rdy
`ifdef SCANOUT_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(H_ACTIVE);
  localparam int VW = $clog2(V_ACTIVE);
  localparam logic [CW:0]   LOW_OCC  = (CW + 1)'(LOW_WATER);
  localparam logic [CW:0]   FULL_OCC = (CW + 1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE - 1);

  arb_state_e        state;
  arb_state_e        state_q;
  rd_tag_e           ret_tag;
  logic              gpu_rd_q;
  logic              ret_valid;
  logic              in_flight;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              urgent;
  logic              can_scan;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  pixel_t            head;
  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] eff_base;
  logic [ADDR_W-1:0] scan_off;
  logic              base_ok;

  // A scan read issued last cycle is in flight until its data is pushed this cycle.
  assign in_flight = (state_q == SCAN);
  assign occ       = {1'b0, count} + {{CW{1'b0}}, in_flight};
  assign urgent    = (occ < LOW_OCC);
  assign can_scan  = (occ < FULL_OCC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gpu_rd_q <= 1'b0;
    end else begin
      state_q  <= state;
      gpu_rd_q <= (state == GPU) && !gpu_we;
    end
  end

  always_comb begin
    state = IDLE;
    if (urgent && can_scan) state = SCAN;
    else if (gpu_req)       state = GPU;
    else if (can_scan)      state = SCAN;
  end

  always_comb begin
    gpu_gnt   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      SCAN: begin
        mem_req  = 1'b1;
        mem_addr = eff_base + scan_off;
      end
      GPU: begin
        gpu_gnt   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = gpu_we;
        mem_addr  = gpu_addr;
        mem_wdata = gpu_wdata;
      end
      default: ;
    endcase
  end

  assign ret_tag    = (state_q == SCAN) ? TAG_SCAN : TAG_GPU;
  assign ret_valid  = in_flight || gpu_rd_q;
  assign push       = ret_valid && (ret_tag == TAG_SCAN) && !fifo_full;
  assign gpu_rvalid = ret_valid && (ret_tag == TAG_GPU);
  assign gpu_rdata  = gpu_rvalid ? mem_rdata : '0;

  // Until the first post-reset cycle has latched the base, scan straight from frame_base.
  assign eff_base = base_ok ? base : frame_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      scan_off <= '0;
      base     <= '0;
      base_ok  <= 1'b0;
    end else begin
      if (!base_ok) begin
        base    <= frame_base;
        base_ok <= 1'b1;
      end
      if (state == SCAN) begin
        if (h == H_LAST) begin
          h <= '0;
          if (v == V_LAST) begin
            v        <= '0;
            scan_off <= '0;
            base     <= frame_base;
          end else begin
            v        <= v + VW'(1);
            scan_off <= scan_off + ADDR_W'(1);
          end
        end else begin
          h        <= h + HW'(1);
          scan_off <= scan_off + ADDR_W'(1);
        end
      end
    end
  end

  pix_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(mem_rdata),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  // Popping only while vid_en is low keeps strobes at most every other cycle.
  assign pop = vid_rdy && !fifo_empty && !vid_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_en   <= 1'b0;
      vid_data <= '0;
    end else begin
      vid_en <= pop;
      if (pop) vid_data <= head;
    end
  end

`ifdef SCANOUT_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (vid_rdy && !vid_en && fifo_empty && !in_flight && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scanout_arb.sv
// Directed self-checking bench for scanout_arb with a small 8x4 raster so frame wraps stay short.
module tb_scanout_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] frame_base = '0;
  logic        gpu_req = 1'b0;
  logic        gpu_we = 1'b0;
  logic [18:0] gpu_addr = '0;
  logic [23:0] gpu_wdata = '0;
  logic        gpu_gnt;
  logic        gpu_rvalid;
  logic [23:0] gpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;
  logic [23:0] vid_data;
  logic        vid_en;
  logic        vid_rdy = 1'b0;
`ifdef SCANOUT_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  scanout_arb #(
    .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(19), .FIFO_DEPTH(16), .LOW_WATER(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_base(frame_base),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vid_data(vid_data), .vid_en(vid_en), .vid_rdy(vid_rdy)
`ifdef SCANOUT_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input logic [18:0] a);
    return {5'h15, a};
  endfunction

  // VRAM model: read data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= pix(mem_addr);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns into the first cycle with rst low.
  task automatic do_reset(input logic [18:0] fb, input logic rdy);
    rst = 1'b1; frame_base = fb; vid_rdy = rdy; gpu_req = 1'b0; gpu_we = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(19'h01000, 1'b0);
    #1;
    n_cmp++; if (vid_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vid_en got %b want 0", vid_en); end
    n_cmp++; if (vid_data !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_vid_data got %h want 0", vid_data); end
    n_cmp++; if (gpu_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gpu_rvalid got %b want 0", gpu_rvalid); end
    n_cmp++; if (gpu_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gpu_gnt got %b want 0", gpu_gnt); end
`ifdef SCANOUT_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_underrun got %h want 0", underrun_cnt); end
`endif
  endtask

  task automatic test_fill;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin step; #1; end
      n_cmp++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 19'(32'h01000 + c)}) begin
        n_fail++;
        $display("[TB] FAIL fill_read%0d got req=%b we=%b addr=%h want req=1 we=0 addr=%h",
                 c, mem_req, mem_we, mem_addr, 19'(32'h01000 + c));
      end
    end
    for (int c = 16; c < 18; c++) begin
      step; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_idle%0d got req=%b want 0", c, mem_req); end
    end
  endtask

  task automatic test_gpu_read;
    step;
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 19'h00100;
    #1;
    n_cmp++;
    if ({gpu_gnt, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 19'h00100}) begin
      n_fail++;
      $display("[TB] FAIL gpu_read_grant got gnt=%b req=%b we=%b addr=%h want 1 1 0 00100",
               gpu_gnt, mem_req, mem_we, mem_addr);
    end
    step;
    gpu_req = 1'b0;
    #1;
    n_cmp++; if (gpu_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL gpu_rvalid got %b want 1", gpu_rvalid); end
    n_cmp++; if (gpu_rdata !== pix(19'h00100)) begin n_fail++; $display("[TB] FAIL gpu_rdata got %h want %h", gpu_rdata, pix(19'h00100)); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL gpu_read_full_idle got req=%b want 0", mem_req); end
    step; #1;
    n_cmp++; if (gpu_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL gpu_rvalid_pulse got %b want 0", gpu_rvalid); end
    step;
    vid_rdy = 1'b1;
    #1;
    step; #1;
    vid_rdy = 1'b0;
    n_cmp++;
    if ({vid_en, vid_data} !== {1'b1, pix(19'h01000)}) begin
      n_fail++;
      $display("[TB] FAIL gpu_read_head got en=%b data=%h want en=1 data=%h", vid_en, vid_data, pix(19'h01000));
    end
  endtask

  task automatic test_latency;
    do_reset(19'h02000, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step;
      #1;
      n_cmp++;
      if (vid_en !== ((c == 3) || (c == 5))) begin
        n_fail++; $display("[TB] FAIL latency_en_c%0d got %b want %b", c, vid_en, ((c == 3) || (c == 5)));
      end
      if (c == 3) begin
        n_cmp++; if (vid_data !== pix(19'h02000)) begin n_fail++; $display("[TB] FAIL latency_px0 got %h want %h", vid_data, pix(19'h02000)); end
      end
      if (c == 5) begin
        n_cmp++; if (vid_data !== pix(19'h02001)) begin n_fail++; $display("[TB] FAIL latency_px1 got %h want %h", vid_data, pix(19'h02001)); end
`ifdef SCANOUT_UNDERRUN_CNT_EN
        n_cmp++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL underrun_once got %0d want 1", underrun_cnt); end
`endif
      end
    end
  endtask

  // GPU writes held high while video pulls one pixel per 8 cycles, draining the full FIFO.
  task automatic test_back_to_back;
    int cnt, infl, occ, n_ven;
    logic ven, exp_gnt, pop_m, scan_seen;
    do_reset(19'h00000, 1'b0);
    for (int i = 0; i < 20; i++) step;
    cnt = 16; infl = 0; ven = 1'b0; n_ven = 0; scan_seen = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step;
      vid_rdy = (c % 8 == 0);
      gpu_req = 1'b1; gpu_we = 1'b1;
      gpu_addr = 19'(32'h04000 + c);
      gpu_wdata = 24'(32'hC00000 + c);
      #1;
      occ = cnt + infl;
      exp_gnt = (occ >= 4);
      n_cmp++;
      if (gpu_gnt !== exp_gnt) begin
        n_fail++; $display("[TB] FAIL b2b_gnt_c%0d occ=%0d got %b want %b", c, occ, gpu_gnt, exp_gnt);
      end
      n_cmp++;
      if (exp_gnt) begin
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, gpu_addr, gpu_wdata}) begin
          n_fail++; $display("[TB] FAIL b2b_write_c%0d got req=%b we=%b addr=%h wd=%h want 1 1 %h %h",
                             c, mem_req, mem_we, mem_addr, mem_wdata, gpu_addr, gpu_wdata);
        end
      end else begin
        scan_seen = 1'b1;
        if ({mem_req, mem_we} !== 2'b10) begin
          n_fail++; $display("[TB] FAIL b2b_scan_c%0d got req=%b we=%b want 1 0", c, mem_req, mem_we);
        end
      end
      n_cmp++;
      if (vid_en !== ven) begin
        n_fail++; $display("[TB] FAIL b2b_vid_en_c%0d got %b want %b", c, vid_en, ven);
      end
      if (vid_en === 1'b1) n_ven++;
      pop_m = vid_rdy && (cnt > 0) && !ven;
      cnt = cnt + infl - (pop_m ? 1 : 0);
      infl = exp_gnt ? 0 : 1;
      ven = pop_m;
    end
    gpu_req = 1'b0; vid_rdy = 1'b0;
    n_cmp++; if (scan_seen !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_urgent_scan got %b want 1", scan_seen); end
    n_cmp++; if (n_ven != 15) begin n_fail++; $display("[TB] FAIL b2b_pixel_count got %0d want 15", n_ven); end
  endtask

  task automatic test_frame_wrap;
    int k;
    logic [18:0] exp_addr;
    k = 0;
    do_reset(19'h00000, 1'b1);
    for (int c = 0; c < 400 && k < 40; c++) begin
      if (c > 0) step;
      if (k == 10) frame_base = 19'h60000;
      #1;
      if (mem_req && !mem_we) begin
        exp_addr = (k < 32) ? 19'(k) : 19'(32'h60000 + k - 32);
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_fail++; $display("[TB] FAIL wrap_addr%0d got %h want %h", k, mem_addr, exp_addr);
        end
        k++;
      end
    end
    n_cmp++; if (k != 40) begin n_fail++; $display("[TB] FAIL wrap_timeout got %0d reads want 40", k); end
  endtask

  task automatic test_rst_midflight;
    do_reset(19'h00200, 1'b1);
    for (int c = 1; c <= 6; c++) step;
    rst = 1'b1; frame_base = 19'h00300;
    #1;
    n_cmp++; if (vid_data !== pix(19'h00201)) begin n_fail++; $display("[TB] FAIL midrst_pre_data got %h want %h", vid_data, pix(19'h00201)); end
    n_cmp++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("[TB] FAIL midrst_inflight got req=%b we=%b want 1 0", mem_req, mem_we); end
    step;
    rst = 1'b0;
    #1;
    n_cmp++; if ({vid_en, vid_data} !== 25'h0) begin n_fail++; $display("[TB] FAIL midrst_vid got en=%b data=%h want 0 0", vid_en, vid_data); end
    n_cmp++; if (gpu_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rvalid got %b want 0", gpu_rvalid); end
    n_cmp++; if (mem_addr !== 19'h00300) begin n_fail++; $display("[TB] FAIL midrst_restart_addr got %h want 00300", mem_addr); end
    for (int c = 1; c <= 3; c++) step;
    #1;
    n_cmp++;
    if ({vid_en, vid_data} !== {1'b1, pix(19'h00300)}) begin
      n_fail++; $display("[TB] FAIL midrst_first_px got en=%b data=%h want 1 %h", vid_en, vid_data, pix(19'h00300));
    end
`ifdef SCANOUT_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL midrst_underrun got %0d want 1", underrun_cnt); end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached after %0d compared", n_cmp);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_fill;
    test_gpu_read;
    test_latency;
    test_back_to_back;
    test_frame_wrap;
    test_rst_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
